note_priority_arbiter: RTL and testbench
========================================

NOTE_PRIORITY_ARBITER -- requirements
Module: note_priority_arbiter

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 12, number of key inputs; legal range 2..16.
REQ-002 SHALL have parameter IDX_W, default 4, key index width; 2^IDX_W >= NUM_KEYS.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port keys  input  NUM_KEYS  debounced key levels, bit i = key i+1, 1 = pressed, synchronous to clk.
REQ-006 SHALL have port sample_tick  input  1  one-cycle strobe marking an audio frame boundary; output update point.
REQ-007 SHALL have port note_idx  output  IDX_W  index (0-based) of the sounding key.
REQ-008 SHALL have port gate  output  1  1 = at least one key held at last tick.
REQ-009 SHALL have port note_change  output  1  one-cycle pulse when the sounding note changes.
REQ-010 SHALL have port held_count  output  IDX_W+1  number of keys in the stack, live.

Function
REQ-011 SHALL keep a register tracked[NUM_KEYS-1:0], the key state already processed.
REQ-012 SHALL keep a press-order stack of NUM_KEYS entries of IDX_W bits plus depth counter (0..NUM_KEYS); entry depth-1 = top = most recent press.
REQ-013 SHALL each cycle select the lowest index i where keys[i] != tracked[i]; at most one event is processed per cycle.
REQ-014 SHALL on a press event (keys[i]=1): write i at position depth, depth+1, set tracked[i].
REQ-015 SHALL on a release event (keys[i]=0): remove the entry equal to i, shift every entry above it down one position, depth-1, clear tracked[i].
REQ-016 SHALL leave other pending differences for later cycles; N simultaneous changes complete in N cycles, lowest index first.
REQ-017 SHALL never overflow: depth cannot exceed NUM_KEYS since each key occupies at most one entry.
REQ-018 SHALL release of a key not found in the stack never occurs; tracked and stack are consistent by construction.
REQ-019 SHALL drive held_count = depth, registered, updated the cycle after the event.
REQ-020 SHALL update note_idx and gate only in a cycle where sample_tick=1, sampling stack state as registered at that edge.
REQ-021 SHALL at a tick with depth>0: note_idx <= top entry, gate <= 1.
REQ-022 SHALL at a tick with depth=0: gate <= 0, note_idx holds its previous value.
REQ-023 SHALL assert note_change for exactly the cycle after a tick where gate goes 0->1, or gate stays 1 and note_idx changes; otherwise 0.
REQ-024 SHALL not assert note_change on gate 1->0.
REQ-025 SHALL if an event and sample_tick coincide, the tick sees pre-event state; the event shows at the next tick.
REQ-026 SHALL produce no combinational path from keys or sample_tick to any output.

Reset
REQ-027 SHALL on rst=1, asynchronously clear tracked, depth, all stack entries, note_idx, gate, note_change, held_count to 0.
REQ-028 SHALL after reset release, treat keys already held as fresh presses, processed lowest index first.
REQ-029 SHALL on reset mid-operation, discard pending events and stack contents with no partial shift completing.

Verification
REQ-030 SHALL single key: press key 4 (idx 3), tick -> note_idx=3, gate=1, note_change pulse, held_count=1; release, tick -> gate=0, note_idx=3, no pulse.
REQ-031 SHALL last-note priority: press idx 2, then idx 7, then release idx 7, ticks between -> note_idx 2,7,2 with pulse each change.
REQ-032 SHALL middle removal: press 1,5,9, release 5 -> held_count 3 then 2, note_idx stays 9, no pulse; release 9 -> note_idx=1.
REQ-033 SHALL simultaneous: keys 0,3,11 rise same cycle -> held_count 1,2,3 on consecutive cycles, top = 11.
REQ-034 SHALL all 12 keys pressed in index order -> held_count=12, note_idx=11; release all at once -> held_count hits 0 after 12 cycles, gate=0 at next tick.
REQ-035 SHALL reset asserted with 3 keys held -> all outputs 0 immediately; on release with keys unchanged, held_count rebuilds to 3 in 3 cycles.

Source files
------------

// File: rtl/note_priority_arbiter.sv
// Last-note-priority keyboard arbiter: tracks key presses in press order and
// publishes the most recently pressed, still-held key at each sample tick.
module note_priority_arbiter #(
   parameter int NUM_KEYS = 12,
   parameter int IDX_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic                sample_tick,
   output logic [IDX_W-1:0]    note_idx,
   output logic                gate,
   output logic                note_change,
   output logic [IDX_W:0]      held_count
);

   localparam int DW = IDX_W + 1;

   logic [NUM_KEYS-1:0] tracked_q, tracked_d;
   logic [IDX_W-1:0]    stack_q [NUM_KEYS];
   logic [IDX_W-1:0]    stack_d [NUM_KEYS];
   logic [DW-1:0]       depth_q, depth_d;
   logic [IDX_W-1:0]    note_idx_q, note_idx_d;
   logic                gate_q, gate_d;
   logic                note_change_q, note_change_d;

   logic                ev_valid;
   logic                ev_press;
   logic [IDX_W-1:0]    ev_idx;
   logic [NUM_KEYS-1:0] ev_onehot;
   logic [IDX_W-1:0]    top;

   // Lowest-index key whose level differs from what has been processed.
   always_comb begin
      ev_valid  = 1'b0;
      ev_press  = 1'b0;
      ev_idx    = '0;
      ev_onehot = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (!ev_valid && (keys[i] != tracked_q[i])) begin
            ev_valid     = 1'b1;
            ev_press     = keys[i];
            ev_idx       = IDX_W'(i);
            ev_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      top = '0;
      for (int unsigned j = 0; j < NUM_KEYS; j++) begin
         if (DW'(j + 1) == depth_q) top = stack_q[j];
      end
   end

   always_comb begin
      logic shift_on;
      shift_on      = 1'b0;
      tracked_d     = tracked_q;
      stack_d       = stack_q;
      depth_d       = depth_q;
      note_idx_d    = note_idx_q;
      gate_d        = gate_q;
      note_change_d = 1'b0;

      // Tick looks only at registered stack state, so a coincident event waits.
      if (sample_tick) begin
         if (depth_q != '0) begin
            note_change_d = !gate_q || (note_idx_q != top);
            note_idx_d    = top;
            gate_d        = 1'b1;
         end else begin
            gate_d = 1'b0;
         end
      end

      if (ev_valid) begin
         tracked_d = tracked_q ^ ev_onehot;
         if (ev_press) begin
            for (int unsigned j = 0; j < NUM_KEYS; j++) begin
               if (DW'(j) == depth_q) stack_d[j] = ev_idx;
            end
            depth_d = depth_q + DW'(1);
         end else begin
            // Entries at and above the released key slide down by one; the
            // slot above the old top is already zero, so the last slot clears.
            for (int unsigned j = 0; j < NUM_KEYS - 1; j++) begin
               if (!shift_on && (DW'(j) < depth_q) && (stack_q[j] == ev_idx))
                  shift_on = 1'b1;
               if (shift_on) stack_d[j] = stack_q[j + 1];
            end
            stack_d[NUM_KEYS-1] = '0;
            depth_d = depth_q - DW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tracked_q     <= '0;
         depth_q       <= '0;
         note_idx_q    <= '0;
         gate_q        <= 1'b0;
         note_change_q <= 1'b0;
         for (int unsigned j = 0; j < NUM_KEYS; j++) stack_q[j] <= '0;
      end else begin
         tracked_q     <= tracked_d;
         depth_q       <= depth_d;
         note_idx_q    <= note_idx_d;
         gate_q        <= gate_d;
         note_change_q <= note_change_d;
         stack_q       <= stack_d;
      end
   end

   assign note_idx    = note_idx_q;
   assign gate        = gate_q;
   assign note_change = note_change_q;
   assign held_count  = depth_q;

endmodule

// File: tb/tb_note_priority_arbiter.sv
// Bench for note_priority_arbiter: directed scenarios plus random key/tick
// traffic, all checked against a queue-based press-order model.
module tb_note_priority_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] keys = '0;
   logic        sample_tick = 1'b0;
   logic [3:0]  note_idx;
   logic        gate;
   logic        note_change;
   logic [4:0]  held_count;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [11:0] m_trk;
   int          m_stk[$];
   logic [3:0]  m_note;
   logic        m_gate;
   logic        m_nc;
   logic [4:0]  m_held;

   logic [10:0] obs, exp_v;
   assign obs   = {note_idx, gate, note_change, held_count};
   assign exp_v = {m_note, m_gate, m_nc, m_held};

   note_priority_arbiter #(.NUM_KEYS(12), .IDX_W(4)) dut (
      .clk(clk), .rst(rst), .keys(keys), .sample_tick(sample_tick),
      .note_idx(note_idx), .gate(gate), .note_change(note_change),
      .held_count(held_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic model_edge(input logic [11:0] k, input logic t);
      int ev;
      ev   = -1;
      m_nc = 1'b0;
      for (int i = 0; i < 12; i++) if (ev < 0 && k[i] != m_trk[i]) ev = i;
      if (t) begin
         if (m_stk.size() > 0) begin
            if (!m_gate || m_note != 4'(m_stk[$])) m_nc = 1'b1;
            m_note = 4'(m_stk[$]);
            m_gate = 1'b1;
         end else begin
            m_gate = 1'b0;
         end
      end
      if (ev >= 0) begin
         if (k[ev]) begin
            m_stk.push_back(ev);
            m_trk[ev] = 1'b1;
         end else begin
            for (int p = 0; p < m_stk.size(); p++) begin
               if (m_stk[p] == ev) begin
                  m_stk.delete(p);
                  break;
               end
            end
            m_trk[ev] = 1'b0;
         end
      end
      m_held = 5'(m_stk.size());
   endtask

   task automatic step(input logic [11:0] k, input logic t);
      @(negedge clk);
      keys = k;
      sample_tick = t;
      model_edge(k, t);
      @(posedge clk);
      #1;
   endtask

   task automatic assert_reset(input logic [11:0] k);
      @(negedge clk);
      keys = k;
      sample_tick = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      m_trk = '0;
      m_stk.delete();
      m_note = '0;
      m_gate = 1'b0;
      m_nc = 1'b0;
      m_held = '0;
   endtask

   // Drops reset at a falling edge; the following rising edge is modelled.
   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      model_edge(keys, sample_tick);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      assert_reset(12'h000);
      checks++;
      if (obs !== 11'h000) begin
         errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, 11'h000);
      end
      release_reset();
      step(12'h000, 1'b1);
      checks++;
      if (obs !== 11'h000 || obs !== exp_v) begin
         errors++; $display("FAIL reset_idle_tick got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_single_key();
      assert_reset(12'h000);
      release_reset();
      step(12'h008, 1'b0);
      checks++;
      if (held_count !== 5'd1 || obs !== exp_v) begin
         errors++; $display("FAIL single_press got=%h exp=%h", obs, exp_v);
      end
      step(12'h008, 1'b1);
      checks++;
      if (note_idx !== 4'd3 || gate !== 1'b1 || note_change !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL single_tick got=%h exp=%h", obs, exp_v);
      end
      step(12'h008, 1'b0);
      checks++;
      if (note_change !== 1'b0 || obs !== exp_v) begin
         errors++; $display("FAIL single_pulse_width got=%h exp=%h", obs, exp_v);
      end
      step(12'h000, 1'b0);
      checks++;
      if (held_count !== 5'd0 || gate !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL single_release got=%h exp=%h", obs, exp_v);
      end
      step(12'h000, 1'b1);
      checks++;
      if (gate !== 1'b0 || note_idx !== 4'd3 || note_change !== 1'b0 || obs !== exp_v) begin
         errors++; $display("FAIL single_gate_off got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_last_note();
      logic [11:0] k2, k27;
      k2  = 12'h004;
      k27 = 12'h084;
      assert_reset(12'h000);
      release_reset();
      step(k2, 1'b0);
      step(k2, 1'b1);
      checks++;
      if (note_idx !== 4'd2 || note_change !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL last_note_first got=%h exp=%h", obs, exp_v);
      end
      step(k27, 1'b0);
      step(k27, 1'b1);
      checks++;
      if (note_idx !== 4'd7 || note_change !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL last_note_second got=%h exp=%h", obs, exp_v);
      end
      step(k2, 1'b0);
      step(k2, 1'b1);
      checks++;
      if (note_idx !== 4'd2 || note_change !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL last_note_fallback got=%h exp=%h", obs, exp_v);
      end
      step(k2, 1'b1);
      checks++;
      if (note_change !== 1'b0 || obs !== exp_v) begin
         errors++; $display("FAIL last_note_steady got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_middle_removal();
      assert_reset(12'h000);
      release_reset();
      step(12'h002, 1'b0);
      step(12'h022, 1'b0);
      step(12'h222, 1'b0);
      step(12'h222, 1'b1);
      checks++;
      if (held_count !== 5'd3 || note_idx !== 4'd9 || note_change !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL middle_three got=%h exp=%h", obs, exp_v);
      end
      step(12'h202, 1'b0);
      checks++;
      if (held_count !== 5'd2 || obs !== exp_v) begin
         errors++; $display("FAIL middle_removed got=%h exp=%h", obs, exp_v);
      end
      step(12'h202, 1'b1);
      checks++;
      if (note_idx !== 4'd9 || note_change !== 1'b0 || obs !== exp_v) begin
         errors++; $display("FAIL middle_no_change got=%h exp=%h", obs, exp_v);
      end
      step(12'h002, 1'b0);
      step(12'h002, 1'b1);
      checks++;
      if (note_idx !== 4'd1 || note_change !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL middle_top_release got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_simultaneous();
      assert_reset(12'h000);
      release_reset();
      for (int c = 1; c <= 3; c++) begin
         step(12'h809, 1'b0);
         checks++;
         if (held_count !== 5'(c) || obs !== exp_v) begin
            errors++; $display("FAIL simul_count_%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      step(12'h809, 1'b1);
      checks++;
      if (note_idx !== 4'd11 || gate !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL simul_top got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_all_keys();
      logic [11:0] k;
      k = '0;
      assert_reset(12'h000);
      release_reset();
      for (int i = 0; i < 12; i++) begin
         k[i] = 1'b1;
         step(k, 1'b0);
      end
      step(k, 1'b1);
      checks++;
      if (held_count !== 5'd12 || note_idx !== 4'd11 || gate !== 1'b1 || obs !== exp_v) begin
         errors++; $display("FAIL all_full got=%h exp=%h", obs, exp_v);
      end
      for (int c = 1; c <= 12; c++) begin
         step(12'h000, 1'b0);
         checks++;
         if (held_count !== 5'(12 - c) || obs !== exp_v) begin
            errors++; $display("FAIL all_drain_%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      step(12'h000, 1'b1);
      checks++;
      if (gate !== 1'b0 || note_change !== 1'b0 || obs !== exp_v) begin
         errors++; $display("FAIL all_gate_off got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] k;
      k = 12'h444;
      assert_reset(12'h000);
      release_reset();
      step(k, 1'b0);
      step(k, 1'b0);
      step(k, 1'b0);
      step(k, 1'b1);
      assert_reset(k);
      checks++;
      if (obs !== 11'h000) begin
         errors++; $display("FAIL midreset_clear got=%h exp=%h", obs, 11'h000);
      end
      release_reset();
      checks++;
      if (held_count !== 5'd1 || obs !== exp_v) begin
         errors++; $display("FAIL midreset_rebuild_1 got=%h exp=%h", obs, exp_v);
      end
      step(k, 1'b0);
      step(k, 1'b0);
      checks++;
      if (held_count !== 5'd3 || obs !== exp_v) begin
         errors++; $display("FAIL midreset_rebuild_3 got=%h exp=%h", obs, exp_v);
      end
      step(k, 1'b0);
      // Reset with events still pending: the stack must restart from empty.
      step(12'h0F0, 1'b0);
      assert_reset(12'h0F0);
      checks++;
      if (obs !== 11'h000) begin
         errors++; $display("FAIL midreset_pending got=%h exp=%h", obs, 11'h000);
      end
      release_reset();
      for (int c = 0; c < 5; c++) step(12'h0F0, 1'b0);
      step(12'h0F0, 1'b1);
      checks++;
      if (held_count !== 5'd4 || note_idx !== 4'd7 || obs !== exp_v) begin
         errors++; $display("FAIL midreset_pending_rebuild got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_random();
      logic [11:0] k;
      logic        t;
      k = '0;
      assert_reset(12'h000);
      release_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 2) == 0) k[$urandom_range(0, 11)] ^= 1'b1;
         if ($urandom_range(0, 15) == 0) k ^= 12'($urandom);
         t = ($urandom_range(0, 2) == 0);
         step(k, t);
         checks++;
         if (obs !== exp_v) begin
            errors++; $display("FAIL random_cycle_%0d got=%h exp=%h", n, obs, exp_v);
         end
      end
   endtask

   initial begin
      m_trk = '0;
      m_note = '0;
      m_gate = 1'b0;
      m_nc = 1'b0;
      m_held = '0;
      test_reset();
      test_single_key();
      test_last_note();
      test_middle_removal();
      test_simultaneous();
      test_all_keys();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
